btb_update_ctrl: RTL and testbench
==================================

Name: btb_update_ctrl

Overview:
Write-port sequencer for the direct-mapped branch target buffer. Queues branch resolutions from execute in a small FIFO and drains them one write per cycle into the BTB. Runs a full-table invalidation sweep after reset and on flush requests (fence.i, context switch), and holds off fetch-side prediction while the sweep runs.

Parameters:
S_INDEX, 5, BTB index width; index = pc[S_INDEX+1:2]
S_BTB, 2**S_INDEX, number of BTB entries swept on flush
FIFO_DEPTH, 4, update queue depth; power of two, at least 2

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
upd_valid  in  1  execute presents a resolved branch/jump this cycle
upd_taken  in  1  resolved taken (pcmux_sel)
upd_hit  in  1  fetch-time BTB hit, carried down the pipeline
upd_pc  in  32  branch PC
upd_target  in  32  resolved target (alu_out)
flush_req  in  1  one-cycle request to invalidate the whole BTB
btb_we  out  1  BTB write enable
btb_index  out  S_INDEX  entry written
btb_tag  out  32  tag written
btb_data  out  32  target written
btb_valid_wr  out  1  valid bit written (0 = invalidate)
flush_busy  out  1  sweep in progress; fetch treats every lookup as a miss
flush_done  out  1  one-cycle pulse on the last sweep write
upd_dropped  out  1  one-cycle pulse; a taken update was discarded because the FIFO was full

Behaviour:
- Clock, reset and polarity: one clock; reset is synchronous and active-high.
- FSM states: IDLE and FLUSH.
- Reset:
  - On an edge with rst=1: state=FLUSH, sweep counter=0, FIFO empty (count=0).
  - While rst is held: btb_we=0, flush_busy=1, flush_done=0, upd_dropped=0, and all updates and flush_req are ignored.
  - The sweep starts in the first cycle after rst deasserts.
- Enqueue: when upd_valid & upd_taken in IDLE or FLUSH, write {upd_pc, upd_target, valid=1}.
  - Accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs in the same cycle.
  - Otherwise the update is discarded and upd_dropped pulses in the next cycle (registered).
- Not-taken resolutions are ignored; see the optional feature.
- Drain (IDLE only): when the FIFO is non-empty, outputs are driven combinationally from the head, and the head pops at the edge. One write per cycle.
  - btb_we=1
  - btb_index=head.pc[S_INDEX+1:2]
  - btb_tag=head.pc
  - btb_data=head.target
  - btb_valid_wr=head.valid
- Latency: an update presented in cycle N into an empty FIFO is written to the BTB in cycle N+1. FIFO order is preserved.
- FLUSH:
  - Each cycle: btb_we=1, btb_index=counter, btb_tag=0, btb_data=0, btb_valid_wr=0; counter increments.
  - When counter==S_BTB-1: flush_done=1 in that cycle; next state IDLE, counter=0.
  - flush_busy=1 throughout FLUSH; flush_busy=0 in IDLE.
  - The FIFO does not drain during FLUSH, but enqueues continue to be accepted; they are written after the sweep.
- flush_req in IDLE:
  - Next state FLUSH, counter=0.
  - FIFO cleared at the same edge; any same-cycle enqueue is also discarded, without an upd_dropped pulse.
  - A same-cycle head write still occurs.
- flush_req in FLUSH: counter restarts at 0 and the FIFO is cleared. flush_done does not pulse for the aborted sweep.
- Wrap: FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits. Counter width is S_INDEX bits.
- When btb_we=0: btb_index, btb_tag, btb_data and btb_valid_wr are 0.

Optional Feature:
BTB_EVICT_EN
- Defined: an update with upd_valid & ~upd_taken & upd_hit enqueues an invalidate entry {upd_pc, 0, valid=0}.
  - It follows the same acceptance and drop rules, and upd_dropped applies to it.
  - When drained it writes btb_valid_wr=0, removing a mispredicting entry.
- Undefined: not-taken resolutions are always ignored and upd_hit is unused.

Test Plan:
1. Reset: hold rst 3 cycles, then release → flush_busy=1 for 32 cycles; btb_index goes 0..31 with btb_valid_wr=0; flush_done pulses with index 31; flush_busy=0 in the next cycle.
2. Single update in IDLE: upd pc=0x0000_0064, target=0x0000_0100, taken, in cycle N → in cycle N+1: btb_we=1, btb_index=25, btb_tag=0x64, btb_data=0x100, btb_valid_wr=1; btb_we=0 in N+2.
3. Overflow during FLUSH: present 6 taken updates on consecutive cycles mid-sweep → first 4 accepted; 2 upd_dropped pulses; after flush_done, 4 writes in issue order on consecutive cycles.
4. Full plus pop: FIFO full in IDLE and a 5th taken update arrives while draining → accepted; no upd_dropped; all 5 written in order.
5. Flush collision: 2 entries queued, then flush_req together with a taken update → head written in that cycle; remaining entry and the new update discarded; no upd_dropped; sweep of 32 follows. A second flush_req at sweep index 10 → index restarts at 0; exactly one flush_done.
6. BTB_EVICT_EN: not-taken update with upd_hit=1 for pc=0x80 → next cycle btb_we=1, btb_index=0, btb_valid_wr=0. Without the macro → no write.

Source files
------------

// File: rtl/btb_update_ctrl_if.sv
// Port bundle for btb_update_ctrl: execute-side update/flush requests and the BTB write port.
// The master modport is the requester side; the slave modport is the sequencer itself.
interface btb_update_ctrl_if #(
    parameter int unsigned S_INDEX = 5
) ();
    logic               upd_valid;
    logic               upd_taken;
    logic               upd_hit;
    logic [31:0]        upd_pc;
    logic [31:0]        upd_target;
    logic               flush_req;
    logic               btb_we;
    logic [S_INDEX-1:0] btb_index;
    logic [31:0]        btb_tag;
    logic [31:0]        btb_data;
    logic               btb_valid_wr;
    logic               flush_busy;
    logic               flush_done;
    logic               upd_dropped;

    modport master (
        output upd_valid, upd_taken, upd_hit, upd_pc, upd_target, flush_req,
        input  btb_we, btb_index, btb_tag, btb_data, btb_valid_wr,
        input  flush_busy, flush_done, upd_dropped
    );

    modport slave (
        input  upd_valid, upd_taken, upd_hit, upd_pc, upd_target, flush_req,
        output btb_we, btb_index, btb_tag, btb_data, btb_valid_wr,
        output flush_busy, flush_done, upd_dropped
    );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB write-port sequencer: queues resolved branches, drains one write per cycle, and runs
// full-table invalidation sweeps. Define BTB_EVICT_EN to enqueue invalidates on not-taken hits.
module btb_update_ctrl #(
    parameter int unsigned S_INDEX    = 5,
    parameter int unsigned S_BTB      = 2**S_INDEX,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    btb_update_ctrl_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [S_INDEX-1:0] CNT_LAST = S_INDEX'(S_BTB - 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StFlush = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [S_INDEX-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               dropped_q, dropped_d;

    logic [31:0]           pc_mem  [FIFO_DEPTH];
    logic [31:0]           tgt_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] vld_mem;

    logic        in_flush, last, pop, push, push_req, push_valid;
    logic [31:0] push_target;

`ifdef BTB_EVICT_EN
    always_comb begin
        push_req    = bus.upd_valid & (bus.upd_taken | bus.upd_hit);
        push_valid  = bus.upd_taken;
        push_target = bus.upd_taken ? bus.upd_target : 32'h0;
    end
`else
    logic unused_hit;
    assign unused_hit = bus.upd_hit;

    always_comb begin
        push_req    = bus.upd_valid & bus.upd_taken;
        push_valid  = 1'b1;
        push_target = bus.upd_target;
    end
`endif

    always_comb begin
        in_flush = (state_q == StFlush);
        last     = in_flush & (cnt_q == CNT_LAST);
        pop      = ~rst & ~in_flush & (count_q != '0);
        // A full FIFO still accepts when its head leaves in the same cycle.
        push      = ~rst & ~bus.flush_req & push_req & ((count_q != DEPTH_C) | pop);
        dropped_d = ~rst & ~bus.flush_req & push_req & (count_q == DEPTH_C) & ~pop;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush_req) begin
            // Restart the sweep and discard everything queued, including this cycle's update.
            state_d  = StFlush;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (in_flush) begin
                if (last) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + S_INDEX'(1);
                end
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFlush;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dropped_q <= dropped_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= bus.upd_pc;
            tgt_mem[wr_ptr_q] <= push_target;
            vld_mem[wr_ptr_q] <= push_valid;
        end
    end

    logic               we;
    logic [S_INDEX-1:0] index;
    logic [31:0]        tag, data;
    logic               valid_wr;

    always_comb begin
        we       = 1'b0;
        index    = '0;
        tag      = '0;
        data     = '0;
        valid_wr = 1'b0;
        if (!rst && in_flush) begin
            we    = 1'b1;
            index = cnt_q;
        end else if (pop) begin
            we       = 1'b1;
            index    = pc_mem[rd_ptr_q][S_INDEX+1:2];
            tag      = pc_mem[rd_ptr_q];
            data     = tgt_mem[rd_ptr_q];
            valid_wr = vld_mem[rd_ptr_q];
        end
    end

    assign bus.btb_we       = we;
    assign bus.btb_index    = index;
    assign bus.btb_tag      = tag;
    assign bus.btb_data     = data;
    assign bus.btb_valid_wr = valid_wr;
    assign bus.flush_busy   = rst | in_flush;
    // An aborted sweep never reports completion.
    assign bus.flush_done   = ~rst & last & ~bus.flush_req;
    assign bus.upd_dropped  = ~rst & dropped_q;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: stimulus pushes expected BTB writes, a negedge monitor
// pops and compares every write and checks quiet outputs on idle cycles.
module tb_btb_update_ctrl;
    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] tag;
        logic [31:0] data;
        logic        vld;
        logic        busy;
        logic        done;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   drops_seen = 0;
    int   drops_exp = 0;
    wr_t  exp_q[$];

    always #5 clk = ~clk;

    btb_update_ctrl_if #(.S_INDEX(5)) bus ();

    btb_update_ctrl #(
        .S_INDEX   (5),
        .S_BTB     (32),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always @(negedge clk) begin
        wr_t got;
        wr_t e;
        got.idx  = bus.btb_index;
        got.tag  = bus.btb_tag;
        got.data = bus.btb_data;
        got.vld  = bus.btb_valid_wr;
        got.busy = bus.flush_busy;
        got.done = bus.flush_done;
        if (rst) begin
            checks++;
            if (bus.btb_we !== 1'b0 || bus.flush_busy !== 1'b1 || bus.flush_done !== 1'b0 ||
                bus.upd_dropped !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: we=%b busy=%b done=%b dropped=%b, need 0 1 0 0",
                         bus.btb_we, bus.flush_busy, bus.flush_done, bus.upd_dropped);
            end
        end else begin
            if (bus.upd_dropped === 1'b1) drops_seen++;
            checks++;
            if (bus.btb_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: idx=%0d tag=%h data=%h vld=%b, none expected",
                             got.idx, got.tag, got.data, got.vld);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL write: got idx=%0d tag=%h data=%h vld=%b busy=%b done=%b, need idx=%0d tag=%h data=%h vld=%b busy=%b done=%b",
                                 got.idx, got.tag, got.data, got.vld, got.busy, got.done,
                                 e.idx, e.tag, e.data, e.vld, e.busy, e.done);
                    end
                end
            end else if (got !== '0 || bus.btb_we !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs: we=%b idx=%0d tag=%h data=%h vld=%b busy=%b done=%b, need all 0",
                         bus.btb_we, got.idx, got.tag, got.data, got.vld, got.busy, got.done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep(input int last_idx, input bit done);
        wr_t e;
        for (int i = 0; i <= last_idx; i++) begin
            e.idx  = 5'(i);
            e.tag  = '0;
            e.data = '0;
            e.vld  = 1'b0;
            e.busy = 1'b1;
            e.done = done && (i == last_idx);
            exp_q.push_back(e);
        end
    endtask

    task automatic exp_upd(input logic [4:0] idx, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic vld);
        wr_t e;
        e.idx  = idx;
        e.tag  = pc;
        e.data = tgt;
        e.vld  = vld;
        e.busy = 1'b0;
        e.done = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                             input logic hit);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_target = tgt;
        bus.upd_taken  = taken;
        bus.upd_hit    = hit;
    endtask

    task automatic clear_inputs();
        bus.upd_valid  = 1'b0;
        bus.upd_taken  = 1'b0;
        bus.upd_hit    = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_target = '0;
        bus.flush_req  = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && bus.flush_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s drained: %0d writes still pending, need 0", name, exp_q.size());
        end
        #1;
        repeat (3) tick();
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (bus.flush_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s flush_done: not seen, need a pulse", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_drops(input string name);
        checks++;
        if (drops_seen != drops_exp) begin
            errors++;
            $display("FAIL %s drops: got %0d pulses, need %0d", name, drops_seen, drops_exp);
        end
    endtask

    initial begin
        logic [31:0] pc;
        clear_inputs();

        // Reset held 3 cycles, then the power-on sweep.
        rst = 1'b1;
        repeat (3) tick();
        push_sweep(31, 1'b1);
        rst = 1'b0;
        wait_drained("reset_sweep");

        // Single update in IDLE, then a not-taken non-hit that must not write.
        drive_upd(32'h0000_0064, 32'h0000_0100, 1'b1, 1'b0);
        exp_upd(5'd25, 32'h0000_0064, 32'h0000_0100, 1'b1);
        tick();
        clear_inputs();
        wait_drained("single_update");
        drive_upd(32'h0000_0200, 32'h0000_0300, 1'b0, 1'b0);
        tick();
        clear_inputs();
        wait_drained("not_taken");

        // Six updates mid-sweep: four queued, two dropped.
        bus.flush_req = 1'b1;
        push_sweep(31, 1'b1);
        tick();
        clear_inputs();
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            pc = 32'h1000 + 32'(4 * i);
            drive_upd(pc, 32'h2000 + 32'(i), 1'b1, 1'b0);
            if (i < 4) exp_upd(pc[6:2], pc, 32'h2000 + 32'(i), 1'b1);
            else drops_exp++;
            tick();
        end
        clear_inputs();
        wait_drained("overflow");
        check_drops("overflow");

        // Full FIFO in the first IDLE cycle accepts a fifth update thanks to the pop.
        bus.flush_req = 1'b1;
        push_sweep(31, 1'b1);
        tick();
        clear_inputs();
        tick();
        for (int i = 0; i < 4; i++) begin
            pc = 32'h3000 + 32'(4 * i);
            drive_upd(pc, 32'h5000 + 32'(i), 1'b1, 1'b0);
            exp_upd(pc[6:2], pc, 32'h5000 + 32'(i), 1'b1);
            tick();
        end
        clear_inputs();
        wait_done("full_pop");
        drive_upd(32'h0000_3010, 32'h0000_5004, 1'b1, 1'b0);
        exp_upd(5'd4, 32'h0000_3010, 32'h0000_5004, 1'b1);
        tick();
        clear_inputs();
        wait_drained("full_pop");
        check_drops("full_pop");

        // Flush collides with a queued pair and a new update; then a restart at index 10.
        bus.flush_req = 1'b1;
        push_sweep(31, 1'b1);
        tick();
        clear_inputs();
        tick();
        drive_upd(32'h0000_4000, 32'h0000_6000, 1'b1, 1'b0);
        exp_upd(5'd0, 32'h0000_4000, 32'h0000_6000, 1'b1);
        tick();
        drive_upd(32'h0000_4004, 32'h0000_6004, 1'b1, 1'b0);
        tick();
        clear_inputs();
        wait_done("collision");
        bus.flush_req = 1'b1;
        drive_upd(32'h0000_4008, 32'h0000_6008, 1'b1, 1'b0);
        push_sweep(10, 1'b0);
        tick();
        clear_inputs();
        repeat (10) tick();
        bus.flush_req = 1'b1;
        push_sweep(31, 1'b1);
        tick();
        clear_inputs();
        wait_drained("collision");
        check_drops("collision");

        // Not-taken hit: an invalidate only when eviction is built in.
        drive_upd(32'h0000_0080, 32'h0000_0999, 1'b0, 1'b1);
`ifdef BTB_EVICT_EN
        exp_upd(5'd0, 32'h0000_0080, 32'h0000_0000, 1'b0);
`endif
        tick();
        clear_inputs();
        wait_drained("evict");
        check_drops("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
